// File: rtl/mux_demux_pkg.sv
// Shared channel codes and FSM states for the 4-to-1 mux and 1-to-4 demux pair.
// The demux side decodes the same channel codes that the mux emits.
package mux_demux_pkg;

    localparam int CH_W = 2;

    localparam logic [CH_W-1:0] CH0 = 2'b00;
    localparam logic [CH_W-1:0] CH1 = 2'b01;
    localparam logic [CH_W-1:0] CH2 = 2'b10;
    localparam logic [CH_W-1:0] CH3 = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Channel index offset from a base, wrapping modulo the number of channels.
    function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base,
                                               input int unsigned       off);
        return base + CH_W'(off);
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-request arbiter: round-robin starting after last_grant,
// or fixed priority (channel 0 highest) when MUX_FIXED_PRIO_EN is defined.
module rr_arb4
    import mux_demux_pkg::*;
(
    input  logic [3:0]      req,
    input  logic [CH_W-1:0] last_grant,
    output logic            grant_valid,
    output logic [CH_W-1:0] grant
);

`ifdef MUX_FIXED_PRIO_EN

    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Walk from lowest priority up so the highest-priority request is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant       = CH0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant       = CH_W'(i);
            end
        end
    end

`else

    logic [CH_W-1:0] idx;

    // Offsets 4 down to 1 so the channel nearest after last_grant wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = CH0;
        idx         = CH0;
        for (int k = 4; k >= 1; k--) begin
            idx = ch_add(last_grant, k);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

`endif

endmodule

// File: rtl/mux4_1_rr_seq.sv
// Clocked 4-to-1 valid/ready mux with a registered output and channel code {S2,S1}.
// Arbitration is round-robin, or fixed priority when MUX_FIXED_PRIO_EN is defined.
module mux4_1_rr_seq
    import mux_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] A2,
    input  logic [DATA_W-1:0] A3,
    input  logic [DATA_W-1:0] A4,
    input  logic              V1,
    input  logic              V2,
    input  logic              V3,
    input  logic              V4,
    output logic              R1,
    output logic              R2,
    output logic              R3,
    output logic              R4,
    output logic [DATA_W-1:0] Y,
    output logic              S2,
    output logic              S1,
    output logic              YV,
    input  logic              YR
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [CH_W-1:0]   code_q, code_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;

    logic              load;
    logic              grant_valid;
    logic [CH_W-1:0]   grant;
    logic [DATA_W-1:0] sel_data;
    logic              accept;

    rr_arb4 u_arb (
        .req         ({V4, V3, V2, V1}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    assign load = (state_q == EMPTY) || YR;

    // Ready is held low during reset so no word is taken while the register is cleared.
    assign accept = load && grant_valid && !rst;
    assign R1     = accept && (grant == CH0);
    assign R2     = accept && (grant == CH1);
    assign R3     = accept && (grant == CH2);
    assign R4     = accept && (grant == CH3);

    always_comb begin
        sel_data = A1;
        case (grant)
            CH0: sel_data = A1;
            CH1: sel_data = A2;
            CH2: sel_data = A3;
            CH3: sel_data = A4;
        endcase
    end

    // A load with no grant empties the register but keeps the last word and code visible.
    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        code_d       = code_q;
        last_grant_d = last_grant_q;
        if (load) begin
            if (grant_valid) begin
                state_d      = FULL;
                y_d          = sel_data;
                code_d       = grant;
                last_grant_d = grant;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            y_q          <= '0;
            code_q       <= CH0;
            last_grant_q <= CH3;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            code_q       <= code_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign Y  = y_q;
    assign S2 = code_q[1];
    assign S1 = code_q[0];
    assign YV = (state_q == FULL);

endmodule

// File: tb/tb_mux4_1_rr_seq.sv
// Directed self-checking bench for mux4_1_rr_seq; fixed-priority checks run
// instead of the round-robin ones when MUX_FIXED_PRIO_EN is defined.
module tb_mux4_1_rr_seq;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] A1, A2, A3, A4;
    logic              V1, V2, V3, V4;
    logic              R1, R2, R3, R4;
    logic [DATA_W-1:0] Y;
    logic              S2, S1, YV;
    logic              YR;

    int checks = 0;
    int errors = 0;

    logic [3:0]  r_vec;
    logic [10:0] out_vec;
    logic [10:0] exp_out;
    logic [7:0]  words [4];

    assign r_vec   = {R4, R3, R2, R1};
    assign out_vec = {YV, S2, S1, Y};

    mux4_1_rr_seq #(.DATA_W(DATA_W)) dut (
        .clk (clk), .rst (rst),
        .A1  (A1),  .A2  (A2),  .A3 (A3), .A4 (A4),
        .V1  (V1),  .V2  (V2),  .V3 (V3), .V4 (V4),
        .R1  (R1),  .R2  (R2),  .R3 (R3), .R4 (R4),
        .Y   (Y),   .S2  (S2),  .S1 (S1), .YV (YV),
        .YR  (YR)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic set_valid(input logic [3:0] v);
        {V4, V3, V2, V1} = v;
    endtask

    task automatic test_reset;
        A1 = 8'h11; A2 = 8'h22; A3 = 8'h33; A4 = 8'h44;
        set_valid(4'b1111);
        YR  = 1'b1;
        rst = 1'b1;
        #3;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (out_vec !== 11'h000) begin
                errors++;
                $display("[TB] FAIL reset_out[%0d] got %h expected %h", n, out_vec, 11'h000);
            end
            checks++;
            if (r_vec !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_ready[%0d] got %b expected %b", n, r_vec, 4'b0000);
            end
            #6;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (r_vec !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL post_reset_ready got %b expected %b", r_vec, 4'b0001);
        end
        tick();
        checks++;
        if (out_vec !== {1'b1, 2'b00, 8'h11}) begin
            errors++;
            $display("[TB] FAIL post_reset_first got %h expected %h", out_vec, {1'b1, 2'b00, 8'h11});
        end
    endtask

    task automatic test_single;
        do_reset();
        A3 = 8'hA5;
        set_valid(4'b0100);
        YR = 1'b1;
        #1;
        checks++;
        if (r_vec !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single_ready got %b expected %b", r_vec, 4'b0100);
        end
        tick();
        checks++;
        if (out_vec !== {1'b1, 2'b10, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL single_out got %h expected %h", out_vec, {1'b1, 2'b10, 8'hA5});
        end
        set_valid(4'b0000);
        #1;
        checks++;
        if (r_vec !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_idle_ready got %b expected %b", r_vec, 4'b0000);
        end
        tick();
        checks++;
        if (out_vec !== {1'b0, 2'b10, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL single_drain got %h expected %h", out_vec, {1'b0, 2'b10, 8'hA5});
        end
        A3 = 8'h33;
    endtask

    task automatic test_round_robin;
        do_reset();
        set_valid(4'b1111);
        YR = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_out = {1'b1, i[1:0], words[i % 4]};
            checks++;
            if (out_vec !== exp_out) begin
                errors++;
                $display("[TB] FAIL rr_out[%0d] got %h expected %h", i, out_vec, exp_out);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        set_valid(4'b1111);
        YR = 1'b1;
        tick();
        tick();
        YR = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (r_vec !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL bp_ready[%0d] got %b expected %b", i, r_vec, 4'b0000);
            end
            tick();
            checks++;
            if (out_vec !== {1'b1, 2'b01, 8'h22}) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d] got %h expected %h", i, out_vec, {1'b1, 2'b01, 8'h22});
            end
        end
        YR = 1'b1;
        #1;
        checks++;
        if (r_vec !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL bp_resume_ready got %b expected %b", r_vec, 4'b0100);
        end
        tick();
        checks++;
        if (out_vec !== {1'b1, 2'b10, 8'h33}) begin
            errors++;
            $display("[TB] FAIL bp_resume_out got %h expected %h", out_vec, {1'b1, 2'b10, 8'h33});
        end
        tick();
        checks++;
        if (out_vec !== {1'b1, 2'b11, 8'h44}) begin
            errors++;
            $display("[TB] FAIL bp_next_out got %h expected %h", out_vec, {1'b1, 2'b11, 8'h44});
        end
    endtask

    task automatic test_wrap_skip;
        logic [3:0]  exp_r   [3];
        logic [10:0] exp_seq [3];
        exp_r   = '{4'b0010, 4'b1000, 4'b0010};
        exp_seq = '{{1'b1, 2'b01, 8'h22}, {1'b1, 2'b11, 8'h44}, {1'b1, 2'b01, 8'h22}};
        do_reset();
        set_valid(4'b1010);
        YR = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (r_vec !== exp_r[i]) begin
                errors++;
                $display("[TB] FAIL wrap_ready[%0d] got %b expected %b", i, r_vec, exp_r[i]);
            end
            tick();
            checks++;
            if (out_vec !== exp_seq[i]) begin
                errors++;
                $display("[TB] FAIL wrap_out[%0d] got %h expected %h", i, out_vec, exp_seq[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        set_valid(4'b1111);
        YR = 1'b1;
        tick();
        tick();
        YR = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_vec !== 11'h000) begin
            errors++;
            $display("[TB] FAIL async_reset_out got %h expected %h", out_vec, 11'h000);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (r_vec !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL async_restart_ready got %b expected %b", r_vec, 4'b0001);
        end
        tick();
        checks++;
        if (out_vec !== {1'b1, 2'b00, 8'h11}) begin
            errors++;
            $display("[TB] FAIL async_restart_out got %h expected %h", out_vec, {1'b1, 2'b00, 8'h11});
        end
    endtask

    task automatic test_fixed_prio;
        do_reset();
        set_valid(4'b1111);
        YR = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (r_vec !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL fixed_ready[%0d] got %b expected %b", i, r_vec, 4'b0001);
            end
            tick();
            checks++;
            if (out_vec !== {1'b1, 2'b00, 8'h11}) begin
                errors++;
                $display("[TB] FAIL fixed_out[%0d] got %h expected %h", i, out_vec, {1'b1, 2'b00, 8'h11});
            end
        end
    endtask

    initial begin
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        test_reset();
`ifdef MUX_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_async_reset();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_1_rr_seq.md
Name: mux4_1_rr_seq

Overview:
- Clocked 4-to-1 multiplexer: the merging end of the 1-to-4 demux channel.
- Collects words from four valid/ready input channels and arbitrates them round-robin.
- Emits one registered output stream carrying a 2-bit channel code {S2,S1}, so a downstream 1-to-4 demux can route each word back to its original lane.

Parameters:
- DATA_W, 8, width of each data word.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- A1..A4  input  DATA_W each  data for channels 0..3 (A1 is channel 0).
- V1..V4  input  1 each  channel valid.
- R1..R4  output  1 each  channel ready; asserted only for the granted channel in a load cycle.
- Y  output  DATA_W  registered output data.
- S2  output  1  registered channel code MSB.
- S1  output  1  registered channel code LSB.
- YV  output  1  output valid.
- YR  input  1  downstream ready.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: Y=0, S2=0, S1=0, YV=0, R1..R4=0, last_grant=3 (channel 0 wins first).
- FSM states:
  - EMPTY: output register holds nothing; YV=0.
  - FULL: YV=1.
- load = (state==EMPTY) || (YR==1).
- Grant is combinational among asserted V:
  - Search order is last_grant+1, +2, +3, +4, mod 4; the first asserted V wins.
  - If no V is asserted, there is no grant.
- Ri = load && grant==i. A channel transfer occurs when Vi && Ri.
- On a load with a grant, at the next edge:
  - Y <= data of the granted channel.
  - {S2,S1} <= grant index.
  - YV <= 1; state goes to FULL.
  - last_grant <= grant.
- On a load with no grant: YV <= 0, state goes to EMPTY; Y, S2, S1 and last_grant hold.
- FULL with YR=0: Y, S2, S1 and YV hold; all R are 0 (backpressure).
- Latency: an input accepted at edge n is visible on Y/YV after edge n. Throughput is one word per cycle when YR is held at 1.
- Simultaneous YR=1 and a new grant in FULL: the output word is consumed and replaced in the same edge; no bubble.
- Fairness: with all four V held at 1 and YR held at 1, the grant order is 0,1,2,3,0,... No channel waits more than 3 transfers.
- Wrap-around: after last_grant=3 the search starts at channel 0.
- Inputs must stay stable while Vi=1 and Ri=0; the block does not re-sample them.
- Reset mid-operation: a word held in FULL is dropped, outputs go to reset values immediately (asynchronous), and arbitration restarts at channel 0.
- Y is never X after reset.

Optional Feature:
- Macro: MUX_FIXED_PRIO_EN.
- Defined: fixed priority, channel 0 highest and channel 3 lowest. last_grant is not used for selection; it is still updated but may be optimized away. A continuously valid channel 0 starves channels 1..3.
- Not defined: round-robin as specified above.

Decomposition:
- Shared package mux_demux_pkg holds:
  - the CH_W=2 localparam;
  - channel-code constants CH0..CH3 (2'b00..2'b11);
  - FSM state constants EMPTY=1'b0, FULL=1'b1.
- The demux side reuses the same channel codes.
- One sub-module: rr_arb4, a 4-request round-robin arbiter.
  - Inputs: req[3:0], last_grant[1:0].
  - Outputs: grant_valid, grant[1:0].
  - Fully combinational. The ifdef selects fixed priority inside it.
- The output register and FSM stay in the top module.

Test Plan:
- Reset: assert rst for 20 ns with V1..V4=1 -> YV=0, Y=0, {S2,S1}=00, R1..R4=0 throughout. After release, the first word out is A1 with {S2,S1}=00.
- Single channel: V3=1, A3=8'hA5, YR=1 -> R3=1 for one cycle. Next edge gives Y=8'hA5, {S2,S1}=10, YV=1. With V3 then dropped, YV=0 on the following edge.
- Round-robin: all V=1, A1..A4 = 11,22,33,44 hex, YR=1 for 8 cycles -> Y sequence 11,22,33,44,11,22,33,44 with codes 00,01,10,11 repeating.
- Backpressure: output FULL with Y=8'h22, YR=0 for 5 cycles, all V=1 -> Y/S2/S1/YV hold and R1..R4=0. When YR returns to 1, the next word is channel 2 (8'h33) with no duplication and no loss.
- Wrap and skip: last_grant=3, only V2 and V4 asserted -> grant order is channel 1 then channel 3; channels 0 and 2 are skipped.
- MUX_FIXED_PRIO_EN defined, all V=1, YR=1 -> Y=8'h11, {S2,S1}=00 every cycle; R2..R4 never asserted.
